gemm_result_drain: RTL

- Downstream stage of the GEMM top: after a GEMM completes, reads the 32-bit result matrix out of the C buffer SRAM in row-major order and streams it out over a valid/ready interface.
- Owns the C-buffer read port (read_enable/address) while busy.
- Absorbs the 1-cycle SRAM read latency and downstream backpressure with an internal 2-entry FIFO, so no result word is dropped or duplicated.

---
 rtl/gemm_result_drain.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/gemm_result_drain.sv
// gemm_result_drain
// Reads a row-major 32-bit result matrix out of the C-buffer SRAM after a
// GEMM completes and streams it over a valid/ready interface.
// A 2-entry FIFO absorbs the 1-cycle SRAM read latency and downstream
// backpressure, so every element is emitted exactly once and in order.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   start                  single-cycle drain request, sampled only in IDLE
//   M_dimension            rows to drain, latched with start
//   N_dimension            columns to drain, latched with start
//   read_enable_C          C-buffer read strobe
//   address_C              C-buffer read address
//   data_out_C             C-buffer read data, valid the cycle after the strobe
//   out_valid/out_ready    output handshake
//   out_data               result element at the FIFO head
//   out_row/out_col        indices of out_data
//   out_last               out_data is the final element
//   busy                   drain in progress
//   done                   one-cycle pulse when the drain ends
//   error                  sticky illegal-dimension flag, cleared by next start
module gemm_result_drain #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            M_dimension,
  input  logic [7:0]            N_dimension,
  output logic                  read_enable_C,
  output logic [ADDR_WIDTH-1:0] address_C,
  input  logic [DATA_WIDTH-1:0] data_out_C,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            out_row,
  output logic [7:0]            out_col,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  localparam logic [7:0] M_MAX = 8'(M);
  localparam logic [7:0] N_MAX = 8'(N);

  state_t state;

  logic [7:0] m_dim;
  logic [7:0] n_dim;
  logic [7:0] rd_row;
  logic [7:0] rd_col;

  // Tags travelling alongside the read that is in flight to the SRAM
  logic       in_flight;
  logic [7:0] tag_row;
  logic [7:0] tag_col;
  logic       tag_last;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [7:0]            fifo_row  [2];
  logic [7:0]            fifo_col  [2];
  logic                  fifo_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic       push;
  logic       pop;
  logic [2:0] level;
  logic       issue_last;
  logic       dims_illegal;
  logic [ADDR_WIDTH-1:0] addr_calc;

  assign push = in_flight;
  assign pop  = (count != 2'd0) && out_ready;

  // A word leaving the FIFO this cycle frees its slot in time for a new read,
  // which is what allows one word per cycle with out_ready held high.
  assign level = {1'b0, count} + {2'b0, in_flight} - {2'b0, pop};

  assign read_enable_C = (state == READ) && (level < 3'd2);

  assign issue_last = (rd_row == m_dim - 8'd1) && (rd_col == n_dim - 8'd1);

  assign dims_illegal = (M_dimension == 8'd0) || (N_dimension == 8'd0) ||
                        (M_dimension > M_MAX) || (N_dimension > N_MAX);

  assign addr_calc = ADDR_WIDTH'(BASE_ADDR)
                   + ADDR_WIDTH'(rd_row) * ADDR_WIDTH'(n_dim)
                   + ADDR_WIDTH'(rd_col);

  assign address_C = read_enable_C ? addr_calc : '0;

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_row   = fifo_row[rd_ptr];
  assign out_col   = fifo_col[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];

  // Control FSM: dimension latch, read counters, status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      m_dim     <= 8'd0;
      n_dim     <= 8'd0;
      rd_row    <= 8'd0;
      rd_col    <= 8'd0;
      in_flight <= 1'b0;
      tag_row   <= 8'd0;
      tag_col   <= 8'd0;
      tag_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= read_enable_C;
      if (read_enable_C) begin
        tag_row  <= rd_row;
        tag_col  <= rd_col;
        tag_last <= issue_last;
      end
      case (state)
        IDLE: begin
          if (start) begin
            m_dim  <= M_dimension;
            n_dim  <= N_dimension;
            rd_row <= 8'd0;
            rd_col <= 8'd0;
            if (dims_illegal) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              error <= 1'b0;
              busy  <= 1'b1;
              state <= READ;
            end
          end
        end
        READ: begin
          if (read_enable_C) begin
            if (rd_col == n_dim - 8'd1) begin
              rd_col <= 8'd0;
              rd_row <= rd_row + 8'd1;
            end else begin
              rd_col <= rd_col + 8'd1;
            end
            if (issue_last) state <= FLUSH;
          end
        end
        FLUSH: begin
          // Leave as soon as the final word is being accepted this cycle
          if (!in_flight && ((count == 2'd0) || (count == 2'd1 && pop))) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 2-entry result FIFO; storage is cleared on reset so outputs read 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_row[i]  <= 8'd0;
        fifo_col[i]  <= 8'd0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= data_out_C;
        fifo_row[wr_ptr]  <= tag_row;
        fifo_col[wr_ptr]  <= tag_col;
        fifo_last[wr_ptr] <= tag_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
